// File: rtl/mem_rd_mc.sv
// mem_rd_mc: memory-read pipeline stage with a request/acknowledge data port.
// Latches the ALU-stage bundle, performs loads over a multi-cycle read port, and
// forwards jump, store and writeback results towards writeback.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   STALL, FLUSH        hold / clear the stage registers (STALL wins over FLUSH)
//   MEM_BUSY            a load is outstanding; upstream must be stalled
//   DO_JMP, NEW_PC      latched jump request (gated by M_VALID) and target
//   A_*                 ALU-stage bundle entering the stage
//   DATA_REQ/ADDR/ACK/RDDATA  bus-aligned read port, request held until ACK
//   M_*                 registered bundle towards writeback; M_REG_D_V carries
//                       extracted load data or the ALU result
module mem_rd_mc #(
    parameter int XLEN        = 32,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              STALL,
    input  logic              FLUSH,
    output logic              MEM_BUSY,
    output logic              DO_JMP,
    output logic [XLEN-1:0]   NEW_PC,
    input  logic [XLEN-1:0]   A_PC,
    input  logic [XLEN-1:0]   A_NEW_PC,
    input  logic [XLEN-1:0]   A_REG_D_V,
    input  logic [XLEN-1:0]   A_LOAD_ADDR,
    input  logic [XLEN-1:0]   A_STORE_ADDR,
    input  logic [XLEN-1:0]   A_STORE_DATA,
    input  logic [31:0]       A_INST,
    input  logic              A_VALID,
    input  logic              A_DO_JMP,
    input  logic              A_LOAD_RDEN,
    input  logic              A_LOAD_SIGNED,
    input  logic              A_STORE_WREN,
    input  logic [4:0]        A_REG_D,
    input  logic [1:0]        A_LOAD_SIZE,
    input  logic [XLEN/8-1:0] A_STORE_STRB,
    output logic              DATA_REQ,
    output logic [XLEN-1:0]   DATA_ADDR,
    input  logic              DATA_ACK,
    input  logic [XLEN-1:0]   DATA_RDDATA,
    output logic [XLEN-1:0]   M_PC,
    output logic [XLEN-1:0]   M_REG_D_V,
    output logic [XLEN-1:0]   M_STORE_ADDR,
    output logic [XLEN-1:0]   M_STORE_DATA,
    output logic [31:0]       M_INST,
    output logic              M_VALID,
    output logic              M_STORE_WREN,
    output logic              M_LOAD_MISALIGN,
    output logic [4:0]        M_REG_D,
    output logic [XLEN/8-1:0] M_STORE_STRB
);
    localparam int SB   = XLEN / 8;
    localparam int OFFW = $clog2(SB);

    typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;

    state_t state, state_n;

    logic [XLEN-1:0] pc_p0, new_pc_p0, reg_d_v_p0, load_addr_p0;
    logic [XLEN-1:0] store_addr_p0, store_data_p0;
    logic [31:0]     inst_p0;
    logic            valid_p0, do_jmp_p0, load_rden_p0, load_signed_p0, store_wren_p0;
    logic [4:0]      reg_d_p0;
    logic [1:0]      load_size_p0;
    logic [SB-1:0]   store_strb_p0;
    logic [XLEN-1:0] rdbuf, drain_addr;

    logic cur_mis, cur_go, a_go, nxt_go, req_wait;

    // Size 11 does not exist on a 32-bit bus; otherwise the natural alignment of
    // the access size is required when checking is enabled.
    function automatic logic misaligned(input logic [2:0] lo, input logic [1:0] size);
        logic bad;
        bad = 1'b0;
        if (XLEN == 32 && size == 2'b11) begin
            bad = 1'b1;
        end else if (ALIGN_CHECK) begin
            case (size)
                2'b01:   bad = lo[0];
                2'b10:   bad = |lo[1:0];
                2'b11:   bad = |lo[2:0];
                default: bad = 1'b0;
            endcase
        end
        return bad;
    endfunction

    // Rotate the addressed lane down to bit 0 (wraps modulo the bus width), then
    // left-justify the field and shift back to zero- or sign-extend it.
    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] data,
                                                input logic [OFFW-1:0] off,
                                                input logic [1:0]      size,
                                                input logic            sgn);
        logic [XLEN-1:0]        rot, up;
        logic signed [XLEN-1:0] s_up;
        int                     sh, width, boff;
        boff  = 8 * int'(off);
        rot   = (data >> boff) | (data << (XLEN - boff));
        width = 8 << size;
        if (width > XLEN) width = XLEN;
        sh    = XLEN - width;
        up    = rot << sh;
        s_up  = signed'(up);
        if (sgn) return $unsigned(s_up >>> sh);
        return up >> sh;
    endfunction

    // Stage boundary: ALU bundle -> stage registers
    always_ff @(posedge CLK) begin
        if (RST || (!STALL && FLUSH)) begin
            pc_p0          <= '0;
            new_pc_p0      <= '0;
            reg_d_v_p0     <= '0;
            load_addr_p0   <= '0;
            store_addr_p0  <= '0;
            store_data_p0  <= '0;
            inst_p0        <= '0;
            valid_p0       <= 1'b0;
            do_jmp_p0      <= 1'b0;
            load_rden_p0   <= 1'b0;
            load_signed_p0 <= 1'b0;
            store_wren_p0  <= 1'b0;
            reg_d_p0       <= '0;
            load_size_p0   <= '0;
            store_strb_p0  <= '0;
        end else if (!STALL) begin
            pc_p0          <= A_PC;
            new_pc_p0      <= A_NEW_PC;
            reg_d_v_p0     <= A_REG_D_V;
            load_addr_p0   <= A_LOAD_ADDR;
            store_addr_p0  <= A_STORE_ADDR;
            store_data_p0  <= A_STORE_DATA;
            inst_p0        <= A_INST;
            valid_p0       <= A_VALID;
            do_jmp_p0      <= A_DO_JMP;
            load_rden_p0   <= A_LOAD_RDEN;
            load_signed_p0 <= A_LOAD_SIGNED;
            store_wren_p0  <= A_STORE_WREN;
            reg_d_p0       <= A_REG_D;
            load_size_p0   <= A_LOAD_SIZE;
            store_strb_p0  <= A_STORE_STRB;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            rdbuf      <= '0;
            drain_addr <= '0;
        end else begin
            state <= state_n;
            if (state == REQ && DATA_ACK) rdbuf <= DATA_RDDATA;
            // The bus still owes an ACK for this address after the entry is gone.
            if (state == REQ && !DATA_ACK && !STALL) drain_addr <= DATA_ADDR;
        end
    end

    assign cur_mis = valid_p0 && load_rden_p0 && misaligned(load_addr_p0[2:0], load_size_p0);
    assign cur_go  = valid_p0 && load_rden_p0 && !cur_mis;
    assign a_go    = !FLUSH && A_VALID && A_LOAD_RDEN && !misaligned(A_LOAD_ADDR[2:0], A_LOAD_SIZE);
    // Entry the registers will hold after this edge wants a read.
    assign nxt_go  = STALL ? cur_go : a_go;

    always_comb begin
        state_n   = state;
        DATA_REQ  = 1'b0;
        DATA_ADDR = '0;
        req_wait  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (!STALL) state_n = a_go ? REQ : IDLE;
            end
            REQ: begin
                DATA_REQ  = 1'b1;
                DATA_ADDR = load_addr_p0 & ~XLEN'(SB - 1);
                req_wait  = !DATA_ACK;
                if (DATA_ACK) state_n = STALL ? DONE : (a_go ? REQ : IDLE);
                else if (!STALL) state_n = DRAIN;
            end
            DRAIN: begin
                DATA_REQ  = 1'b1;
                DATA_ADDR = drain_addr;
                if (DATA_ACK) state_n = nxt_go ? REQ : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign MEM_BUSY = req_wait || (state == DRAIN);
    assign M_VALID  = valid_p0 && !req_wait && (state != DRAIN);
    assign DO_JMP   = do_jmp_p0 && M_VALID;
    assign NEW_PC   = new_pc_p0;

    always_comb begin
        M_REG_D_V = reg_d_v_p0;
        if (cur_go)
            M_REG_D_V = extract((state == DONE) ? rdbuf : DATA_RDDATA,
                                load_addr_p0[OFFW-1:0], load_size_p0, load_signed_p0);
        else if (cur_mis)
            M_REG_D_V = '0;
    end

    assign M_REG_D         = cur_mis ? 5'd0 : reg_d_p0;
    assign M_LOAD_MISALIGN = cur_mis;
    assign M_PC            = pc_p0;
    assign M_INST          = inst_p0;
    assign M_STORE_ADDR    = store_addr_p0;
    assign M_STORE_DATA    = store_data_p0;
    assign M_STORE_WREN    = store_wren_p0;
    assign M_STORE_STRB    = store_strb_p0;

endmodule

// File: tb/tb_mem_rd_mc.sv
// Testbench for mem_rd_mc: a 32-bit and a 64-bit instance share all stage inputs
// except A_VALID and DATA_ACK, so each step exercises one instance while the
// other only sees bubbles. Expected values come from a byte-lane load model.
module tb_mem_rd_mc;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST, STALL, FLUSH;
    logic [63:0] a_pc, a_new_pc, a_reg_d_v, a_load_addr, a_store_addr, a_store_data, rddata;
    logic [31:0] a_inst;
    logic        a_do_jmp, a_rden, a_sgn, a_wren;
    logic [4:0]  a_reg_d;
    logic [1:0]  a_size;
    logic [7:0]  a_strb;
    logic        v32, v64, ack32, ack64;

    logic        busy32, jmp32, req32, val32, wren32, mis32;
    logic [31:0] npc32, addr32, pc32, rdv32, sa32, sd32, inst32;
    logic [4:0]  rd32;
    logic [3:0]  strb32;
    logic        busy64, jmp64, req64, val64, wren64, mis64;
    logic [63:0] npc64, addr64, pc64, rdv64, sa64, sd64;
    logic [31:0] inst64;
    logic [4:0]  rd64;
    logic [7:0]  strb64;

    mem_rd_mc #(.XLEN(32), .ALIGN_CHECK(1'b1)) u32 (
        .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .MEM_BUSY(busy32),
        .DO_JMP(jmp32), .NEW_PC(npc32), .A_PC(a_pc[31:0]), .A_NEW_PC(a_new_pc[31:0]),
        .A_REG_D_V(a_reg_d_v[31:0]), .A_LOAD_ADDR(a_load_addr[31:0]),
        .A_STORE_ADDR(a_store_addr[31:0]), .A_STORE_DATA(a_store_data[31:0]),
        .A_INST(a_inst), .A_VALID(v32), .A_DO_JMP(a_do_jmp), .A_LOAD_RDEN(a_rden),
        .A_LOAD_SIGNED(a_sgn), .A_STORE_WREN(a_wren), .A_REG_D(a_reg_d),
        .A_LOAD_SIZE(a_size), .A_STORE_STRB(a_strb[3:0]), .DATA_REQ(req32),
        .DATA_ADDR(addr32), .DATA_ACK(ack32), .DATA_RDDATA(rddata[31:0]),
        .M_PC(pc32), .M_REG_D_V(rdv32), .M_STORE_ADDR(sa32), .M_STORE_DATA(sd32),
        .M_INST(inst32), .M_VALID(val32), .M_STORE_WREN(wren32),
        .M_LOAD_MISALIGN(mis32), .M_REG_D(rd32), .M_STORE_STRB(strb32)
    );

    mem_rd_mc #(.XLEN(64), .ALIGN_CHECK(1'b1)) u64 (
        .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .MEM_BUSY(busy64),
        .DO_JMP(jmp64), .NEW_PC(npc64), .A_PC(a_pc), .A_NEW_PC(a_new_pc),
        .A_REG_D_V(a_reg_d_v), .A_LOAD_ADDR(a_load_addr), .A_STORE_ADDR(a_store_addr),
        .A_STORE_DATA(a_store_data), .A_INST(a_inst), .A_VALID(v64), .A_DO_JMP(a_do_jmp),
        .A_LOAD_RDEN(a_rden), .A_LOAD_SIGNED(a_sgn), .A_STORE_WREN(a_wren),
        .A_REG_D(a_reg_d), .A_LOAD_SIZE(a_size), .A_STORE_STRB(a_strb),
        .DATA_REQ(req64), .DATA_ADDR(addr64), .DATA_ACK(ack64), .DATA_RDDATA(rddata),
        .M_PC(pc64), .M_REG_D_V(rdv64), .M_STORE_ADDR(sa64), .M_STORE_DATA(sd64),
        .M_INST(inst64), .M_VALID(val64), .M_STORE_WREN(wren64),
        .M_LOAD_MISALIGN(mis64), .M_REG_D(rd64), .M_STORE_STRB(strb64)
    );

    // Observed bundle of the instance under test.
    logic        sel;
    logic        o_busy, o_jmp, o_req, o_val, o_wren, o_mis;
    logic [63:0] o_npc, o_addr, o_pc, o_rdv, o_sa, o_sd;
    logic [31:0] o_inst;
    logic [4:0]  o_rd;
    logic [7:0]  o_strb;

    always_comb begin
        o_busy = busy32; o_jmp = jmp32; o_req = req32; o_val = val32;
        o_wren = wren32; o_mis = mis32; o_npc = {32'd0, npc32}; o_addr = {32'd0, addr32};
        o_pc = {32'd0, pc32}; o_rdv = {32'd0, rdv32}; o_sa = {32'd0, sa32};
        o_sd = {32'd0, sd32}; o_inst = inst32; o_rd = rd32; o_strb = {4'd0, strb32};
        if (sel) begin
            o_busy = busy64; o_jmp = jmp64; o_req = req64; o_val = val64;
            o_wren = wren64; o_mis = mis64; o_npc = npc64; o_addr = addr64;
            o_pc = pc64; o_rdv = rdv64; o_sa = sa64; o_sd = sd64;
            o_inst = inst64; o_rd = rd64; o_strb = strb64;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a load reads 2**size consecutive bytes starting at the lane
    // addressed within the bus word, little-endian, then extends to XLEN.
    function automatic bit mdl_mis(input int xlen, input logic [63:0] addr, input logic [1:0] size);
        int nb;
        nb = 1 << size;
        if (xlen == 32 && size == 2'b11) return 1'b1;
        return (addr % nb) != 0;
    endfunction

    function automatic logic [63:0] mdl_load(input int xlen, input logic [63:0] data,
                                             input logic [63:0] addr, input logic [1:0] size,
                                             input bit sgn);
        logic [7:0]  bytes [8];
        logic [63:0] v;
        int          nb, bus, off;
        nb  = 1 << size;
        bus = xlen / 8;
        off = int'(addr % bus);
        v   = 64'd0;
        for (int i = 0; i < 8; i++) bytes[i] = data[8*i +: 8];
        for (int i = 0; i < nb; i++) v = v | (64'(bytes[(off + i) % bus]) << (8 * i));
        if (sgn && nb * 8 < xlen && bytes[(off + nb - 1) % bus][7])
            v = v | ~((64'd1 << (8 * nb)) - 64'd1);
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    task automatic idle_inputs();
        v32 = 1'b0; v64 = 1'b0; ack32 = 1'b0; ack64 = 1'b0;
        STALL = 1'b0; FLUSH = 1'b0;
    endtask

    task automatic set_ack(input bit is64, input logic a);
        if (is64) ack64 = a; else ack32 = a;
    endtask

    task automatic set_entry(input bit is64, input logic [63:0] addr, input logic [1:0] size,
                             input bit sgn, input bit rden);
        a_pc = {$urandom, $urandom};        a_new_pc = {$urandom, $urandom};
        a_reg_d_v = {$urandom, $urandom};   a_store_addr = {$urandom, $urandom};
        a_store_data = {$urandom, $urandom}; a_inst = $urandom;
        a_do_jmp = 1'($urandom);            a_wren = 1'($urandom);
        a_strb = 8'($urandom);              a_reg_d = 5'($urandom_range(1, 31));
        a_load_addr = addr; a_size = size; a_sgn = sgn; a_rden = rden;
        v32 = !is64; v64 = is64;
    endtask

    // One load from entry to retirement: lat wait cycles before ACK, then hold
    // cycles of STALL after ACK (DONE) while DATA_RDDATA wanders.
    task automatic do_load(input bit is64, input logic [63:0] addr, input logic [1:0] size,
                           input bit sgn, input int lat, input int hold, input logic [63:0] data);
        int          xlen;
        logic [63:0] msk, exp_v, exp_a;
        logic [4:0]  exp_rd;
        xlen  = is64 ? 64 : 32;
        msk   = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        exp_v = mdl_load(xlen, data, addr, size, sgn);
        exp_a = addr & ~64'(xlen / 8 - 1) & msk;
        sel = is64;
        STALL = 1'b0; FLUSH = 1'b0; set_ack(is64, 1'b0);
        set_entry(is64, addr, size, sgn, 1'b1);
        exp_rd = a_reg_d;
        @(posedge CLK); #1;
        v32 = 1'b0; v64 = 1'b0;
        if (mdl_mis(xlen, addr, size)) begin
            @(negedge CLK);
            chk("mis_flag", 64'(o_mis), 64'd1);
            chk("mis_req", 64'(o_req), 64'd0);
            chk("mis_rd", 64'(o_rd), 64'd0);
            chk("mis_valid", 64'(o_val), 64'd1);
            chk("mis_busy", 64'(o_busy), 64'd0);
        end else begin
            for (int k = 0; k < lat; k++) begin
                STALL = 1'b1; rddata = {$urandom, $urandom};
                @(negedge CLK);
                chk("wait_busy", 64'(o_busy), 64'd1);
                chk("wait_valid", 64'(o_val), 64'd0);
                chk("wait_req", 64'(o_req), 64'd1);
                chk("wait_addr", o_addr, exp_a);
                @(posedge CLK); #1;
            end
            set_ack(is64, 1'b1); rddata = data; STALL = (hold > 0);
            @(negedge CLK);
            chk("ack_busy", 64'(o_busy), 64'd0);
            chk("ack_valid", 64'(o_val), 64'd1);
            chk("ack_req", 64'(o_req), 64'd1);
            chk("ack_addr", o_addr, exp_a);
            chk("ack_data", o_rdv, exp_v);
            chk("ack_rd", 64'(o_rd), 64'(exp_rd));
            chk("ack_mis", 64'(o_mis), 64'd0);
            @(posedge CLK); #1;
            set_ack(is64, 1'b0);
            for (int h = 0; h < hold; h++) begin
                STALL = (h != hold - 1); rddata = {$urandom, $urandom};
                @(negedge CLK);
                chk("done_data", o_rdv, exp_v);
                chk("done_valid", 64'(o_val), 64'd1);
                chk("done_busy", 64'(o_busy), 64'd0);
                chk("done_req", 64'(o_req), 64'd0);
                @(posedge CLK); #1;
            end
            STALL = 1'b0;
            @(negedge CLK);
            chk("after_valid", 64'(o_val), 64'd0);
            chk("after_req", 64'(o_req), 64'd0);
        end
        @(posedge CLK); #1;
    endtask

    task automatic pass_entry(input bit is64);
        logic [63:0] msk, e_pc, e_npc, e_rdv, e_sa, e_sd;
        logic [31:0] e_inst;
        logic [7:0]  e_strb;
        logic [4:0]  e_rd;
        logic        e_jmp, e_wren;
        msk = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        sel = is64; idle_inputs();
        set_entry(is64, {$urandom, $urandom}, 2'($urandom), 1'($urandom), 1'b0);
        e_pc = a_pc & msk; e_npc = a_new_pc & msk; e_rdv = a_reg_d_v & msk;
        e_sa = a_store_addr & msk; e_sd = a_store_data & msk; e_inst = a_inst;
        e_strb = is64 ? a_strb : (a_strb & 8'h0F); e_rd = a_reg_d;
        e_jmp = a_do_jmp; e_wren = a_wren;
        @(posedge CLK); #1;
        v32 = 1'b0; v64 = 1'b0;
        @(negedge CLK);
        chk("pass_valid", 64'(o_val), 64'd1);
        chk("pass_pc", o_pc, e_pc);
        chk("pass_newpc", o_npc, e_npc);
        chk("pass_jmp", 64'(o_jmp), 64'(e_jmp));
        chk("pass_rdv", o_rdv, e_rdv);
        chk("pass_rd", 64'(o_rd), 64'(e_rd));
        chk("pass_inst", 64'(o_inst), 64'(e_inst));
        chk("pass_sa", o_sa, e_sa);
        chk("pass_sd", o_sd, e_sd);
        chk("pass_wren", 64'(o_wren), 64'(e_wren));
        chk("pass_strb", 64'(o_strb), 64'(e_strb));
        chk("pass_req", 64'(o_req), 64'd0);
        @(posedge CLK); #1;
    endtask

    bit          r64, r_sgn;
    logic [1:0]  r_size;
    logic [63:0] r_addr, e_pc1, e_b;
    int          r_nb, r_bus;

    initial begin
        sel = 1'b0; RST = 1'b1; idle_inputs(); rddata = '0;
        a_pc = '0; a_new_pc = '0; a_reg_d_v = '0; a_load_addr = '0; a_store_addr = '0;
        a_store_data = '0; a_inst = '0; a_do_jmp = 1'b0; a_rden = 1'b0; a_sgn = 1'b0;
        a_wren = 1'b0; a_reg_d = '0; a_size = '0; a_strb = '0;
        repeat (2) @(posedge CLK);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s); #1;
            chk("rst_busy", 64'(o_busy), 64'd0);
            chk("rst_req", 64'(o_req), 64'd0);
            chk("rst_valid", 64'(o_val), 64'd0);
            chk("rst_pc", o_pc, 64'd0);
            chk("rst_rdv", o_rdv, 64'd0);
        end
        @(posedge CLK); #1;
        RST = 1'b0;

        // Byte signed, zero-wait; half unsigned, 3 wait cycles.
        do_load(1'b0, 64'h103, 2'b00, 1'b1, 0, 0, 64'h80FF_1234);
        do_load(1'b0, 64'h202, 2'b01, 1'b0, 3, 0, 64'hBEEF_0000);
        // 64-bit: doubleword one cycle late, signed word in the upper lane.
        do_load(1'b1, 64'h1000, 2'b11, 1'b0, 1, 0, 64'h0123_4567_89AB_CDEF);
        do_load(1'b1, 64'h1004, 2'b10, 1'b1, 0, 0, 64'h8000_0000_0000_0000);
        // Misaligned word; illegal doubleword on the 32-bit instance.
        do_load(1'b0, 64'h302, 2'b10, 1'b0, 0, 0, 64'h0);
        do_load(1'b0, 64'h308, 2'b11, 1'b0, 0, 0, 64'h0);
        // ACK under STALL, result held from the buffer for two cycles.
        do_load(1'b0, 64'h601, 2'b00, 1'b0, 1, 2, 64'h1122_3344);
        do_load(1'b1, 64'h7006, 2'b01, 1'b1, 0, 2, 64'hF00D_0000_0000_0000);

        pass_entry(1'b0);
        pass_entry(1'b1);

        // Flush with a load outstanding; a new load entry is latched during drain.
        sel = 1'b0; idle_inputs();
        set_entry(1'b0, 64'h400, 2'b10, 1'b0, 1'b1);
        @(posedge CLK); #1;
        v32 = 1'b0; FLUSH = 1'b1;
        @(negedge CLK);
        chk("fl_busy", 64'(o_busy), 64'd1);
        chk("fl_valid", 64'(o_val), 64'd0);
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        set_entry(1'b0, 64'h505, 2'b00, 1'b0, 1'b1);
        e_b = mdl_load(32, 64'hA1B2_C3D4, 64'h505, 2'b00, 1'b0);
        @(negedge CLK);
        chk("drain_req", 64'(o_req), 64'd1);
        chk("drain_addr", o_addr, 64'h400);
        chk("drain_busy", 64'(o_busy), 64'd1);
        chk("drain_valid", 64'(o_val), 64'd0);
        @(posedge CLK); #1;
        v32 = 1'b0; STALL = 1'b1; ack32 = 1'b1; rddata = {$urandom, $urandom};
        @(negedge CLK);
        chk("drain2_addr", o_addr, 64'h400);
        chk("drain2_busy", 64'(o_busy), 64'd1);
        chk("drain2_valid", 64'(o_val), 64'd0);
        @(posedge CLK); #1;
        STALL = 1'b0; rddata = 64'hA1B2_C3D4;
        @(negedge CLK);
        chk("newld_addr", o_addr, 64'h504);
        chk("newld_valid", 64'(o_val), 64'd1);
        chk("newld_data", o_rdv, e_b);
        chk("newld_busy", 64'(o_busy), 64'd0);
        @(posedge CLK); #1;
        ack32 = 1'b0;
        @(negedge CLK);
        chk("newld_idle", 64'(o_req), 64'd0);
        @(posedge CLK); #1;

        // STALL overrides FLUSH; FLUSH alone clears the stage.
        sel = 1'b0; idle_inputs();
        set_entry(1'b0, 64'h0, 2'b00, 1'b0, 1'b0);
        e_pc1 = a_pc & 64'hFFFF_FFFF;
        @(posedge CLK); #1;
        a_pc = ~a_pc; STALL = 1'b1; FLUSH = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("stfl_pc", o_pc, e_pc1);
        chk("stfl_valid", 64'(o_val), 64'd1);
        STALL = 1'b0;
        @(posedge CLK); #1;
        FLUSH = 1'b0; v32 = 1'b0;
        @(negedge CLK);
        chk("flush_valid", 64'(o_val), 64'd0);
        chk("flush_pc", o_pc, 64'd0);
        @(posedge CLK); #1;

        // Reset while a request is outstanding.
        sel = 1'b1; idle_inputs();
        set_entry(1'b1, 64'h2000, 2'b11, 1'b0, 1'b1);
        @(posedge CLK); #1;
        v64 = 1'b0; STALL = 1'b1; RST = 1'b1;
        @(negedge CLK);
        chk("prerst_busy", 64'(o_busy), 64'd1);
        @(posedge CLK); #1;
        RST = 1'b0; STALL = 1'b0;
        @(negedge CLK);
        chk("rstreq_req", 64'(o_req), 64'd0);
        chk("rstreq_busy", 64'(o_busy), 64'd0);
        chk("rstreq_valid", 64'(o_val), 64'd0);
        chk("rstreq_pc", o_pc, 64'd0);
        chk("rstreq_addr", o_addr, 64'd0);
        chk("rstreq_inst", 64'(o_inst), 64'd0);
        @(posedge CLK); #1;

        // Randomized loads on both widths.
        for (int i = 0; i < 60; i++) begin
            r64    = 1'($urandom);
            r_size = 2'($urandom);
            r_sgn  = 1'($urandom);
            r_nb   = 1 << r_size;
            r_bus  = r64 ? 8 : 4;
            r_addr = {$urandom, $urandom} & ~64'h7;
            if (!r64) r_addr[63:32] = 32'd0;
            if ($urandom_range(0, 3) == 0) r_addr = r_addr + 64'($urandom_range(0, 7));
            else if (r_nb <= r_bus) r_addr = r_addr + 64'(r_nb * $urandom_range(0, r_bus / r_nb - 1));
            do_load(r64, r_addr, r_size, r_sgn, $urandom_range(0, 3),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0,
                    {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
